// File: rtl/l1_victim_buffer_pkg.sv
// Shared types for the L1 victim buffer: entry layout, FSM states, block geometry.
package l1_victim_buffer_pkg;

  localparam int BLOCK_W = 128;
  localparam int BLK_AW  = 30;

  typedef struct packed {
    logic              valid;
    logic [BLK_AW-1:0] addr;
    logic [BLOCK_W-1:0] data;
  } victimEntry_t;

  typedef enum logic [1:0] {
    VB_IDLE,
    VB_RD_L2,
    VB_WR_L2
  } vbState_t;

endpackage

// File: rtl/l1_victim_buffer_cam_match.sv
// Address CAM over the victim entries; a masked-out entry never matches.
module victim_cam_match
  import l1_victim_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0][BLK_AW-1:0] addrs_i,
  input  logic [BLK_AW-1:0]            addr_i,
  output logic                         hit_o,
  output logic [IW-1:0]                hit_idx_o
);

  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_i[i] && (addrs_i[i] == addr_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/l1_victim_buffer.sv
// Victim FIFO between L1 and L2: coalesces dirty evictions, forwards fill hits,
// and drains to L2 in the background with read misses taking priority.
//   state    | meaning
//   VB_IDLE  | accepting reads; picks next L2 transaction
//   VB_RD_L2 | fill read outstanding at L2
//   VB_WR_L2 | head entry being written back to L2
module l1_victim_buffer
  import l1_victim_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wb_valid_i,
  output logic               wb_ready_o,
  input  logic [BLK_AW-1:0]  wb_addr_i,
  input  logic [BLOCK_W-1:0] wb_data_i,
  input  logic               rd_req_i,
  output logic               rd_ready_o,
  input  logic [BLK_AW-1:0]  rd_addr_i,
  output logic               rd_valid_o,
  output logic [BLOCK_W-1:0] rd_data_o,
  output logic               l2_req_o,
  output logic               l2_we_o,
  output logic [BLK_AW-1:0]  l2_addr_o,
  output logic [BLOCK_W-1:0] l2_wdata_o,
  input  logic               l2_ack_i,
  input  logic [BLOCK_W-1:0] l2_rdata_i,
  output logic [CW-1:0]      count_o
);

  victimEntry_t entries_q [DEPTH];
  victimEntry_t entries_d [DEPTH];
  logic [IW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  vbState_t           state_q, state_d;
  logic [BLK_AW-1:0]  rd_addr_q, rd_addr_d;
  logic               rd_valid_q, rd_valid_d;
  logic [BLOCK_W-1:0] rd_data_q, rd_data_d;

  logic [DEPTH-1:0]             valid_vec, co_mask;
  logic [DEPTH-1:0][BLK_AW-1:0] addr_vec;
  logic                         co_hit, rd_cam_hit;
  logic [IW-1:0]                co_idx, rd_idx;
  logic push, pop, rd_acc, fwd_push, rd_hit;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entries_q[i].valid;
      addr_vec[i]  = entries_q[i].addr;
      // The head under write-back is frozen; a new push to its address gets its own entry.
      co_mask[i]   = entries_q[i].valid &&
                     !((state_q == VB_WR_L2) && (head_q == IW'(i)));
    end
  end

  victim_cam_match #(.DEPTH(DEPTH), .IW(IW)) u_cam_push (
    .valid_i   (co_mask),
    .addrs_i   (addr_vec),
    .addr_i    (wb_addr_i),
    .hit_o     (co_hit),
    .hit_idx_o (co_idx)
  );

  victim_cam_match #(.DEPTH(DEPTH), .IW(IW)) u_cam_read (
    .valid_i   (valid_vec),
    .addrs_i   (addr_vec),
    .addr_i    (rd_addr_i),
    .hit_o     (rd_cam_hit),
    .hit_idx_o (rd_idx)
  );

  assign wb_ready_o = !reset && (count_q != CW'(DEPTH));
  assign rd_ready_o = !reset && (state_q == VB_IDLE);
  assign push       = wb_valid_i && wb_ready_o;
  assign rd_acc     = rd_req_i && rd_ready_o;
  assign fwd_push   = push && (wb_addr_i == rd_addr_i);
  assign rd_hit     = fwd_push || rd_cam_hit;
  assign pop        = (state_q == VB_WR_L2) && l2_ack_i;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (pop) begin
      entries_d[head_q].valid = 1'b0;
      head_d = head_q + 1'b1;
    end
    if (push) begin
      if (co_hit) begin
        entries_d[co_idx].data = wb_data_i;
      end else begin
        entries_d[tail_q].valid = 1'b1;
        entries_d[tail_q].addr  = wb_addr_i;
        entries_d[tail_q].data  = wb_data_i;
        tail_d = tail_q + 1'b1;
      end
    end
    count_d = count_q + CW'(push && !co_hit) - CW'(pop);
  end

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    case (state_q)
      VB_IDLE: begin
        if (rd_acc && rd_hit) begin
          rd_valid_d = 1'b1;
          rd_data_d  = fwd_push ? wb_data_i : entries_q[rd_idx].data;
        end
        if (rd_acc && !rd_hit) begin
          state_d   = VB_RD_L2;
          rd_addr_d = rd_addr_i;
        end else if (count_q != '0) begin
          state_d = VB_WR_L2;
        end
      end
      VB_RD_L2: begin
        if (l2_ack_i) begin
          rd_valid_d = 1'b1;
          rd_data_d  = l2_rdata_i;
          state_d    = VB_IDLE;
        end
      end
      VB_WR_L2: begin
        if (l2_ack_i) state_d = VB_IDLE;
      end
      default: state_d = VB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i].valid <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      state_q    <= VB_IDLE;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      entries_q  <= entries_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign l2_req_o   = !reset && (state_q != VB_IDLE);
  assign l2_we_o    = !reset && (state_q == VB_WR_L2);
  assign l2_addr_o  = reset                  ? '0 :
                      (state_q == VB_RD_L2)  ? rd_addr_q :
                      (state_q == VB_WR_L2)  ? entries_q[head_q].addr : '0;
  assign l2_wdata_o = (!reset && (state_q == VB_WR_L2)) ? entries_q[head_q].data : '0;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign count_o    = count_q;

endmodule
